// File: rtl/cache_pkg.sv
// Shared types and constants for the cache port arbiter: FSM states, master IDs, default widths.
package cache_pkg;

  localparam int unsigned DefBits        = 32;
  localparam int unsigned DefAddressBits = 28;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StRd0,
    StRd1,
    StWr1
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; remembers the last granted master and favours the other on conflict.
module rr_arb2
  import cache_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_valid_o = |req_i;
    if (&req_i) begin
      gnt_id_o = ~last_q;
    end else begin
      gnt_id_o = req_i[1] ? M1 : M0;
    end
    last_d = (update_i && gnt_valid_o) ? gnt_id_o : last_q;
  end

  // Reset to M1 so that M0 wins the first conflict.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= M1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Arbitrates an instruction-fetch read master (M0) and a read/write data master (M1) onto one
// cache CPU port. One transaction at a time; request fields are latched on grant.
module cache_port_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned BITS         = DefBits,
  parameter int unsigned ADDRESS_BITS = DefAddressBits
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  // M0: instruction fetch
  input  logic [ADDRESS_BITS-1:0] m0_addr,
  input  logic                    m0_rd_req,
  output logic                    m0_rd_valid,
  output logic [BITS-1:0]         m0_data_out,
  // M1: data port
  input  logic [ADDRESS_BITS-1:0] m1_addr,
  input  logic [BITS-1:0]         m1_data_in,
  input  logic [3:0]              m1_wstrb,
  input  logic                    m1_wr_valid,
  output logic                    m1_wr_ready,
  input  logic                    m1_rd_req,
  output logic                    m1_rd_valid,
  output logic [BITS-1:0]         m1_data_out,
  // Cache CPU port
  output logic [ADDRESS_BITS-1:0] cpu_addr,
  output logic [BITS-1:0]         cpu_data_in,
  output logic [3:0]              cpu_wstrb,
  output logic                    cpu_wr_valid,
  input  logic                    cpu_wr_ready,
  output logic                    cpu_rd_ready,
  input  logic                    cpu_rd_valid,
  input  logic [BITS-1:0]         cpu_data_out,
  output logic                    busy
);

  state_e                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [BITS-1:0]         data_q, data_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic                    rd_ready_q, rd_ready_d;
  logic                    wr_valid_q, wr_valid_d;
  logic                    busy_q, busy_d;

  logic gnt_valid;
  logic gnt_id;

  rr_arb2 u_rr_arb2 (
    .clk_i       (CLK),
    .rst_i       (RSTb),
    .req_i       ({m1_wr_valid | m1_rd_req, m0_rd_req}),
    .update_i    (state_q == StIdle),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wstrb_d = wstrb_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          if (gnt_id == M0) begin
            state_d = StRd0;
            addr_d  = m0_addr;
            data_d  = '0;
            wstrb_d = '0;
          end else if (m1_wr_valid) begin
            // Writes go ahead of a simultaneous M1 read.
            state_d = StWr1;
            addr_d  = m1_addr;
            data_d  = m1_data_in;
            wstrb_d = m1_wstrb;
          end else begin
            state_d = StRd1;
            addr_d  = m1_addr;
            data_d  = '0;
            wstrb_d = '0;
          end
        end
      end
      StRd0, StRd1: begin
        if (cpu_rd_valid) begin
          state_d = StIdle;
        end
      end
      StWr1: begin
        if (cpu_wr_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    rd_ready_d = (state_d == StRd0) || (state_d == StRd1);
    wr_valid_d = (state_d == StWr1);
    busy_d     = (state_d != StIdle);
  end

  always_ff @(posedge CLK) begin
    if (RSTb) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      data_q     <= '0;
      wstrb_q    <= '0;
      rd_ready_q <= 1'b0;
      wr_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wstrb_q    <= wstrb_d;
      rd_ready_q <= rd_ready_d;
      wr_valid_q <= wr_valid_d;
      busy_q     <= busy_d;
    end
  end

  // Response pulses are decoded from the registered state, so a late cache response in IDLE is dropped.
  assign m0_rd_valid  = (state_q == StRd0) && cpu_rd_valid;
  assign m1_rd_valid  = (state_q == StRd1) && cpu_rd_valid;
  assign m1_wr_ready  = (state_q == StWr1) && cpu_wr_ready;
  assign m0_data_out  = cpu_data_out;
  assign m1_data_out  = cpu_data_out;

  assign cpu_addr     = addr_q;
  assign cpu_data_in  = data_q;
  assign cpu_wstrb    = wstrb_q;
  assign cpu_rd_ready = rd_ready_q;
  assign cpu_wr_valid = wr_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model.
module tb_cache_port_arbiter;

  localparam int AB = 28;

  logic          CLK = 1'b0;
  logic          RSTb;
  logic [AB-1:0] m0_addr, m1_addr;
  logic          m0_rd_req, m1_wr_valid, m1_rd_req;
  logic [31:0]   m1_data_in;
  logic [3:0]    m1_wstrb;
  logic          m0_rd_valid, m1_wr_ready, m1_rd_valid;
  logic [31:0]   m0_data_out, m1_data_out;
  logic [AB-1:0] cpu_addr;
  logic [31:0]   cpu_data_in;
  logic [3:0]    cpu_wstrb;
  logic          cpu_wr_valid, cpu_wr_ready, cpu_rd_ready, cpu_rd_valid;
  logic [31:0]   cpu_data_out;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  cache_port_arbiter #(
    .BITS         (32),
    .ADDRESS_BITS (AB)
  ) dut (
    .CLK          (CLK),
    .RSTb         (RSTb),
    .m0_addr      (m0_addr),
    .m0_rd_req    (m0_rd_req),
    .m0_rd_valid  (m0_rd_valid),
    .m0_data_out  (m0_data_out),
    .m1_addr      (m1_addr),
    .m1_data_in   (m1_data_in),
    .m1_wstrb     (m1_wstrb),
    .m1_wr_valid  (m1_wr_valid),
    .m1_wr_ready  (m1_wr_ready),
    .m1_rd_req    (m1_rd_req),
    .m1_rd_valid  (m1_rd_valid),
    .m1_data_out  (m1_data_out),
    .cpu_addr     (cpu_addr),
    .cpu_data_in  (cpu_data_in),
    .cpu_wstrb    (cpu_wstrb),
    .cpu_wr_valid (cpu_wr_valid),
    .cpu_wr_ready (cpu_wr_ready),
    .cpu_rd_ready (cpu_rd_ready),
    .cpu_rd_valid (cpu_rd_valid),
    .cpu_data_out (cpu_data_out),
    .busy         (busy)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Transaction model: kind 0 = none, 1 = M0 read, 2 = M1 read, 3 = M1 write.
  int            kind;
  logic          last;
  logic [AB-1:0] l_addr;
  logic [31:0]   l_data;
  logic [3:0]    l_strb;
  logic          r0, r1, win;
  logic          e_m0r, e_m1r, e_m1w;
  logic          seen_m0, seen_m1r, seen_m1w;

  initial begin
    seen_m0  = 1'b0;
    seen_m1r = 1'b0;
    seen_m1w = 1'b0;
    @(posedge CLK);
    kind   = 0;
    last   = 1'b1;
    l_addr = '0;
    l_data = '0;
    l_strb = '0;
    forever begin
      @(negedge CLK);
      e_m0r = (kind == 1) && cpu_rd_valid;
      e_m1r = (kind == 2) && cpu_rd_valid;
      e_m1w = (kind == 3) && cpu_wr_ready;
      chk("busy", 64'(busy), 64'(kind != 0));
      chk("cpu_rd_ready", 64'(cpu_rd_ready), 64'((kind == 1) || (kind == 2)));
      chk("cpu_wr_valid", 64'(cpu_wr_valid), 64'(kind == 3));
      chk("rd_wr_exclusive", 64'(cpu_rd_ready && cpu_wr_valid), 64'(0));
      chk("cpu_addr", 64'(cpu_addr), 64'(l_addr));
      chk("cpu_data_in", 64'(cpu_data_in), 64'(l_data));
      chk("cpu_wstrb", 64'(cpu_wstrb), 64'(l_strb));
      chk("m0_rd_valid", 64'(m0_rd_valid), 64'(e_m0r));
      chk("m1_rd_valid", 64'(m1_rd_valid), 64'(e_m1r));
      chk("m1_wr_ready", 64'(m1_wr_ready), 64'(e_m1w));
      chk("m0_data_out", 64'(m0_data_out), 64'(cpu_data_out));
      chk("m1_data_out", 64'(m1_data_out), 64'(cpu_data_out));
      seen_m0  = e_m0r;
      seen_m1r = e_m1r;
      seen_m1w = e_m1w;
      // Inputs are stable from here until the next rising edge, so advance the model now.
      if (RSTb) begin
        kind   = 0;
        last   = 1'b1;
        l_addr = '0;
        l_data = '0;
        l_strb = '0;
      end else if (kind == 0) begin
        r0 = m0_rd_req;
        r1 = m1_wr_valid || m1_rd_req;
        if (r0 || r1) begin
          win  = (r0 && r1) ? ~last : !r0;
          last = win;
          if (!win) begin
            kind = 1; l_addr = m0_addr; l_data = '0; l_strb = '0;
          end else if (m1_wr_valid) begin
            kind = 3; l_addr = m1_addr; l_data = m1_data_in; l_strb = m1_wstrb;
          end else begin
            kind = 2; l_addr = m1_addr; l_data = '0; l_strb = '0;
          end
        end
      end else if (e_m0r || e_m1r || e_m1w) begin
        kind = 0;
      end
    end
  end

  initial begin
    RSTb = 1'b1;
    m0_addr = '0; m0_rd_req = 1'b0;
    m1_addr = '0; m1_data_in = '0; m1_wstrb = '0; m1_wr_valid = 1'b0; m1_rd_req = 1'b0;
    cpu_wr_ready = 1'b0; cpu_rd_valid = 1'b0; cpu_data_out = '0;
    repeat (3) tick();
    RSTb = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_addr", 64'(cpu_addr), 64'(0));

    // Single M0 fetch.
    tick(); m0_addr = 28'h100; m0_rd_req = 1'b1;
    tick(); #1;
    chk("t37_rd_ready", 64'(cpu_rd_ready), 64'(1));
    chk("t37_addr", 64'(cpu_addr), 64'h100);
    cpu_rd_valid = 1'b1; cpu_data_out = 32'hDEADBEEF; #1;
    chk("t37_m0_valid", 64'(m0_rd_valid), 64'(1));
    chk("t37_m0_data", 64'(m0_data_out), 64'hDEADBEEF);
    tick(); m0_rd_req = 1'b0; cpu_rd_valid = 1'b0; #1;
    chk("t37_idle", 64'(busy), 64'(0));

    // Conflicts after a fresh reset: M0 first, then a repeated conflict goes to M1.
    tick(); RSTb = 1'b1;
    tick(); RSTb = 1'b0;
    tick(); m0_addr = 28'h200; m0_rd_req = 1'b1; m1_addr = 28'h300; m1_rd_req = 1'b1;
    tick(); #1;
    chk("t38_first_addr", 64'(cpu_addr), 64'h200);
    cpu_rd_valid = 1'b1; cpu_data_out = 32'h0000_0A0A; #1;
    chk("t38_first_m0", 64'(m0_rd_valid), 64'(1));
    chk("t38_first_m1", 64'(m1_rd_valid), 64'(0));
    tick(); cpu_rd_valid = 1'b0; m0_addr = 28'h204;
    tick(); #1;
    chk("t38_second_addr", 64'(cpu_addr), 64'h300);
    cpu_rd_valid = 1'b1; #1;
    chk("t38_second_m1", 64'(m1_rd_valid), 64'(1));
    chk("t38_second_m0", 64'(m0_rd_valid), 64'(0));
    tick(); cpu_rd_valid = 1'b0; m1_rd_req = 1'b0;
    tick(); #1;
    chk("t38_third_addr", 64'(cpu_addr), 64'h204);
    cpu_rd_valid = 1'b1; #1;
    chk("t38_third_m0", 64'(m0_rd_valid), 64'(1));
    tick(); cpu_rd_valid = 1'b0; m0_rd_req = 1'b0;

    // Write with a stalled cache; inputs scrambled after grant.
    tick(); m1_addr = 28'h20; m1_data_in = 32'h12345678; m1_wstrb = 4'hF; m1_wr_valid = 1'b1;
    tick(); m1_addr = 28'h3FF; m1_data_in = 32'hFFFF0000; m1_wstrb = 4'h1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t39_wr_valid", 64'(cpu_wr_valid), 64'(1));
      chk("t39_addr", 64'(cpu_addr), 64'h20);
      chk("t39_data", 64'(cpu_data_in), 64'h12345678);
      chk("t39_strb", 64'(cpu_wstrb), 64'hF);
      chk("t39_no_ready", 64'(m1_wr_ready), 64'(0));
      tick();
    end
    cpu_wr_ready = 1'b1; #1;
    chk("t39_ready", 64'(m1_wr_ready), 64'(1));
    tick(); cpu_wr_ready = 1'b0; m1_wr_valid = 1'b0; #1;
    chk("t39_ready_once", 64'(m1_wr_ready), 64'(0));
    chk("t39_idle", 64'(busy), 64'(0));

    // Simultaneous M1 write and read: write first.
    tick(); m1_addr = 28'h40; m1_data_in = 32'hCAFEF00D; m1_wstrb = 4'h3;
    m1_wr_valid = 1'b1; m1_rd_req = 1'b1;
    tick(); #1;
    chk("t40_wr_valid", 64'(cpu_wr_valid), 64'(1));
    chk("t40_no_rd", 64'(cpu_rd_ready), 64'(0));
    cpu_wr_ready = 1'b1; #1;
    chk("t40_wr_ready", 64'(m1_wr_ready), 64'(1));
    chk("t40_no_rd_valid", 64'(m1_rd_valid), 64'(0));
    tick(); cpu_wr_ready = 1'b0; m1_wr_valid = 1'b0; m1_addr = 28'h44;
    tick(); #1;
    chk("t40_rd_ready", 64'(cpu_rd_ready), 64'(1));
    chk("t40_rd_addr", 64'(cpu_addr), 64'h44);
    cpu_rd_valid = 1'b1; cpu_data_out = 32'h5A5A5A5A; #1;
    chk("t40_rd_valid", 64'(m1_rd_valid), 64'(1));
    chk("t40_rd_data", 64'(m1_data_out), 64'h5A5A5A5A);
    tick(); cpu_rd_valid = 1'b0; m1_rd_req = 1'b0;

    // Reset in the middle of an M1 read; the late response must be ignored.
    tick(); m1_addr = 28'h80; m1_rd_req = 1'b1;
    tick(); #1;
    chk("t41_rd1", 64'(cpu_rd_ready), 64'(1));
    RSTb = 1'b1; m1_rd_req = 1'b0;
    tick(); RSTb = 1'b0; cpu_rd_valid = 1'b1; #1;
    chk("t41_no_valid", 64'(m1_rd_valid), 64'(0));
    chk("t41_busy", 64'(busy), 64'(0));
    chk("t41_addr", 64'(cpu_addr), 64'(0));
    tick(); cpu_rd_valid = 1'b0; #1;
    chk("t41_still_idle", 64'(busy), 64'(0));

    // Random traffic with occasional resets and early request drops.
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (seen_m0) m0_rd_req = 1'b0;
      else if (!m0_rd_req && ($urandom % 3 == 0)) m0_rd_req = 1'b1;
      else if (m0_rd_req && ($urandom % 25 == 0)) m0_rd_req = 1'b0;
      if (seen_m1w) m1_wr_valid = 1'b0;
      else if (!m1_wr_valid && ($urandom % 4 == 0)) m1_wr_valid = 1'b1;
      else if (m1_wr_valid && ($urandom % 25 == 0)) m1_wr_valid = 1'b0;
      if (seen_m1r) m1_rd_req = 1'b0;
      else if (!m1_rd_req && ($urandom % 4 == 0)) m1_rd_req = 1'b1;
      else if (m1_rd_req && ($urandom % 25 == 0)) m1_rd_req = 1'b0;
      m0_addr      = AB'($urandom);
      m1_addr      = AB'($urandom);
      m1_data_in   = $urandom;
      m1_wstrb     = 4'($urandom);
      cpu_rd_valid = ($urandom % 3 == 0);
      cpu_wr_ready = ($urandom % 3 == 0);
      cpu_data_out = $urandom;
      RSTb         = ($urandom % 150 == 0);
    end
    tick();
    RSTb = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
